// File: rtl/multdiv_pkg.sv
// Shared decode constants, FSM encoding and default width for the iterative multiply/divide unit.
// Constants only: no latency, no backpressure.
package multdiv_pkg;
   localparam int MD_WIDTH = 32;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/multdiv_ctrl_md_datapath.sv
// Booth multiplier / non-restoring divider datapath with combinational sign fix-up; one bit per step.
// Result is valid WIDTH steps after load; no backpressure (the controller sequences load/step).
module md_datapath
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             is_div,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             exception
);
   logic [2*WIDTH:0]   preg;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH:0]     booth_acc, booth_sum, mcand_ext;
   logic [WIDTH+1:0]   rem, rem_sh, rem_nxt, dsor_ext;
   logic [WIDTH-1:0]   quo, dsor, a_mag, b_mag, quo_fix;
   logic [2*WIDTH-1:0] prod;
   logic               div_op, q_neg, div_zero, div_ovf, mul_ovf;

   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;

   // Accumulator is widened by one bit so adding/subtracting the most negative multiplicand cannot wrap.
   always_comb begin
      booth_acc = {preg[2*WIDTH], preg[2*WIDTH:WIDTH+1]};
      mcand_ext = {mcand[WIDTH-1], mcand};
      booth_sum = booth_acc;
      case (preg[1:0])
         2'b01:   booth_sum = booth_acc + mcand_ext;
         2'b10:   booth_sum = booth_acc - mcand_ext;
         default: booth_sum = booth_acc;
      endcase
   end

   assign rem_sh   = {rem[WIDTH:0], quo[WIDTH-1]};
   assign dsor_ext = {2'b00, dsor};
   assign rem_nxt  = rem[WIDTH+1] ? (rem_sh + dsor_ext) : (rem_sh - dsor_ext);

   always_ff @(posedge clock) begin
      if (reset) begin
         preg     <= '0;
         mcand    <= '0;
         rem      <= '0;
         quo      <= '0;
         dsor     <= '0;
         div_op   <= 1'b0;
         q_neg    <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
      end else if (load) begin
         div_op   <= is_div;
         mcand    <= a;
         // A zero operand yields an all-zero register that Booth steps leave untouched.
         preg     <= ((a == '0) || (b == '0)) ? '0 : {{WIDTH{1'b0}}, b, 1'b0};
         rem      <= '0;
         quo      <= a_mag;
         dsor     <= b_mag;
         q_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
         div_zero <= (b == '0);
         div_ovf  <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      end else if (step) begin
         if (div_op) begin
            rem <= rem_nxt;
            quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
         end else begin
            preg <= {booth_sum, preg[WIDTH:1]};
         end
      end
   end

   assign prod    = preg[2*WIDTH:1];
   assign mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
   assign quo_fix = q_neg ? -quo : quo;

   assign result    = div_op ? (div_zero ? '0 : quo_fix) : prod[WIDTH-1:0];
   assign exception = div_op ? (div_zero | div_ovf) : mul_ovf;
endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage mul/div controller: decode, FSM, counter, mul_stall; optional MULTDIV_EARLY_OUT_EN.
// Result strobes WIDTH+1 cycles after DX entry (1 on early-out); holds the pipeline via mul_stall meanwhile.
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      dx_ir,
   input  logic [WIDTH-1:0] dx_a,
   input  logic [WIDTH-1:0] dx_b,
   output logic             mul_stall,
   output logic [WIDTH-1:0] md_result,
   output logic             md_valid,
   output logic             md_exception
);
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             dx_md, is_div, early, load, step;
   logic [WIDTH-1:0] dp_result;
   logic             dp_exception;
   logic             ir_unused;

   assign is_div    = (dx_ir[6:2] == ALU_DIV);
   assign dx_md     = (dx_ir[31:27] == OP_RTYPE) && ((dx_ir[6:2] == ALU_MUL) || is_div);
   assign ir_unused = ^{dx_ir[26:7], dx_ir[1:0]};

`ifdef MULTDIV_EARLY_OUT_EN
   assign early = is_div ? (dx_b == '0) : ((dx_a == '0) || (dx_b == '0));
`else
   assign early = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (dx_md) begin
                  cnt   <= '0;
                  state <= early ? ST_DONE : (is_div ? ST_DIV : ST_MUL);
               end
            end
            ST_MUL, ST_DIV: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) state <= ST_DONE;
            end
            // DONE lasts one cycle so the advancing instruction is never restarted.
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign load = (state == ST_IDLE) && dx_md;
   assign step = (state == ST_MUL) || (state == ST_DIV);

   md_datapath #(.WIDTH(WIDTH)) u_dp (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .is_div    (is_div),
      .step      (step),
      .a         (dx_a),
      .b         (dx_b),
      .result    (dp_result),
      .exception (dp_exception)
   );

   assign mul_stall    = !reset && (load || step);
   assign md_valid     = !reset && (state == ST_DONE);
   assign md_result    = md_valid ? dp_result : '0;
   assign md_exception = md_valid && dp_exception;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: directed vector table, reset-abort and back-to-back sequences, random ops vs arithmetic model.
module tb_multdiv_ctrl;
   logic        clock;
   logic        reset;
   logic [31:0] dx_ir, dx_a, dx_b;
   logic        mul_stall, md_valid, md_exception;
   logic [31:0] md_result;

   int checks = 0;
   int errors = 0;

   multdiv_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .dx_ir        (dx_ir),
      .dx_a         (dx_a),
      .dx_b         (dx_b),
      .mul_stall    (mul_stall),
      .md_result    (md_result),
      .md_valid     (md_valid),
      .md_exception (md_exception)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
   } vec_t;

   vec_t vt[15];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] make_ir(input logic is_div);
      logic [31:0] r;
      r = $urandom;
      return {5'b00000, r[26:7], (is_div ? 5'b00111 : 5'b00110), r[1:0]};
   endfunction

   function automatic int exp_lat(input logic is_div, input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_OUT_EN
      if (is_div ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
      return 33;
   endfunction

   // Architectural reference: 64-bit signed arithmetic, C-style truncating division.
   task automatic ref_md(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
      longint sa, sb, p;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      if (!is_div) begin
         p = sa * sb;
         r = p[31:0];
         e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
      end else if (sb == 0) begin
         r = 32'd0;
         e = 1'b1;
      end else begin
         p = sa / sb;
         r = p[31:0];
         e = (p > 64'sd2147483647);
      end
   endtask

   // Starts at a negedge; returns at the negedge following the md_valid cycle.
   task automatic run_md(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output int stalls, output logic vld,
                         output logic stall_done, output logic [31:0] res, output logic exc);
      dx_ir = ir; dx_a = a; dx_b = b;
      cycles = 0; stalls = 0; vld = 1'b0; stall_done = 1'b0; res = '0; exc = 1'b0;
      for (int c = 0; c < 100 && !vld; c++) begin
         #1;
         if (md_valid) begin
            vld = 1'b1; stall_done = mul_stall; res = md_result; exc = md_exception;
         end else begin
            cycles++;
            if (mul_stall) stalls++;
         end
         @(negedge clock);
      end
   endtask

   task automatic idle_check(input string name, input logic [31:0] ir, input int n);
      logic bad;
      bad = 1'b0;
      dx_ir = ir; dx_a = $urandom; dx_b = $urandom;
      for (int c = 0; c < n; c++) begin
         #1;
         if (mul_stall || md_valid || md_exception || md_result != 0) bad = 1'b1;
         @(negedge clock);
      end
      check(name, {31'd0, bad}, 32'd0);
   endtask

   task automatic check_op(input string name, input logic is_div, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eres, input logic eexc);
      int cyc, stl;
      logic vld, sd, exc;
      logic [31:0] res;
      run_md(make_ir(is_div), a, b, cyc, stl, vld, sd, res, exc);
      check({name, " valid"}, {31'd0, vld}, 32'd1);
      check({name, " cycles"}, cyc, exp_lat(is_div, a, b));
      check({name, " stalls"}, stl, exp_lat(is_div, a, b));
      check({name, " stall_at_done"}, {31'd0, sd}, 32'd0);
      check({name, " result"}, res, eres);
      check({name, " exception"}, {31'd0, exc}, {31'd0, eexc});
      idle_check({name, " no_repeat"}, 32'h0000_0000, 1);
   endtask

   initial begin
      logic [31:0] ra, rb, rr;
      logic        rdiv, re, bad;
      int          cyc, stl;
      logic        vld, sd, exc;
      logic [31:0] res;

      vt[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
      vt[1]  = '{1'b0, 32'h00010000,  32'h00010000, 32'h00000000, 1'b1};
      vt[2]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0};
      vt[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1};
      vt[4]  = '{1'b1, 32'd5,         32'd0,        32'h00000000, 1'b1};
      vt[5]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1};
      vt[6]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001, 1'b0};
      vt[7]  = '{1'b0, 32'h80000000,  32'd1,        32'h80000000, 1'b0};
      vt[8]  = '{1'b1, 32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
      vt[9]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'h0000000E, 1'b0};
      vt[10] = '{1'b0, 32'd0,         32'd5,        32'h00000000, 1'b0};
      vt[11] = '{1'b0, 32'h0000FFFF,  32'h0000FFFF, 32'hFFFE0001, 1'b1};
      vt[12] = '{1'b1, 32'h7FFFFFFF,  32'h80000000, 32'h00000000, 1'b0};
      vt[13] = '{1'b0, 32'h00010000,  32'hFFFF8000, 32'h80000000, 1'b0};
      vt[14] = '{1'b1, 32'd0,         32'd0,        32'h00000000, 1'b1};

      // Reset held with an md instruction present: all outputs quiet.
      reset = 1'b1; dx_ir = 32'h0000_0018; dx_a = 32'd7; dx_b = 32'd3;
      repeat (2) @(negedge clock);
      #1;
      check("reset mul_stall", {31'd0, mul_stall}, 32'd0);
      check("reset md_valid", {31'd0, md_valid}, 32'd0);
      check("reset md_exception", {31'd0, md_exception}, 32'd0);
      check("reset md_result", md_result, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      idle_check("post_reset idle", 32'h0000_0000, 2);

      // Non-md encodings must not stall.
      idle_check("decode wrong_opcode", 32'h0800_0018, 2);
      idle_check("decode alu_add", 32'h0000_0004, 2);
      idle_check("decode alu_8", 32'h0000_0020, 2);

      for (int i = 0; i < 15; i++)
         check_op($sformatf("tbl%0d", i), vt[i].is_div, vt[i].a, vt[i].b, vt[i].res, vt[i].exc);

      // Reset at iteration 10 of a MUL, instruction still in DX afterwards.
      dx_ir = make_ir(1'b0); dx_a = 32'h00012345; dx_b = 32'hFFFFFFB3;
      bad = 1'b0;
      for (int c = 0; c < 11; c++) begin
         #1;
         if (md_valid || !mul_stall) bad = 1'b1;
         @(negedge clock);
      end
      check("abort pre_stall", {31'd0, bad}, 32'd0);
      reset = 1'b1;
      #1;
      check("abort reset stall", {31'd0, mul_stall}, 32'd0);
      check("abort reset valid", {31'd0, md_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      ref_md(1'b0, 32'h00012345, 32'hFFFFFFB3, rr, re);
      run_md(dx_ir, dx_a, dx_b, cyc, stl, vld, sd, res, exc);
      check("abort restart valid", {31'd0, vld}, 32'd1);
      check("abort restart stalls", stl, 33);
      check("abort restart cycles", cyc, 33);
      check("abort restart result", res, rr);
      check("abort restart exception", {31'd0, exc}, {31'd0, re});
      idle_check("abort no_repeat", 32'h0000_0000, 2);

      // Back-to-back MUL 3*4 then DIV 12/4: only the DONE cycle is non-stalling in between.
      run_md(make_ir(1'b0), 32'd3, 32'd4, cyc, stl, vld, sd, res, exc);
      check("b2b mul valid", {31'd0, vld}, 32'd1);
      check("b2b mul stalls", stl, 33);
      check("b2b mul result", res, 32'd12);
      run_md(make_ir(1'b1), 32'd12, 32'd4, cyc, stl, vld, sd, res, exc);
      check("b2b div valid", {31'd0, vld}, 32'd1);
      check("b2b div first_cycle_stall", cyc, 33);
      check("b2b div stalls", stl, 33);
      check("b2b div result", res, 32'd3);
      check("b2b div exception", {31'd0, exc}, 32'd0);
      idle_check("b2b no_repeat", 32'h0000_0000, 3);

      for (int i = 0; i < 40; i++) begin
         rdiv = 1'(($urandom_range(0, 1)));
         for (int k = 0; k < 2; k++) begin
            logic [31:0] v;
            case ($urandom_range(0, 7))
               0: v = 32'd0;
               1: v = 32'd1;
               2: v = 32'hFFFFFFFF;
               3: v = 32'h80000000;
               4: v = 32'h7FFFFFFF;
               5: v = 32'($urandom_range(0, 31)) - 32'd16;
               default: v = $urandom;
            endcase
            if (k == 0) ra = v; else rb = v;
         end
         ref_md(rdiv, ra, rb, rr, re);
         check_op($sformatf("rand%0d %s %h %h", i, rdiv ? "div" : "mul", ra, rb), rdiv, ra, rb, rr, re);
         if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d gap", i), 32'h0000_0000, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Iterative signed multiply/divide unit in the execute stage. It is the producer of the `mul_stall` signal that the hazard/stall unit consumes.
- Detects a mul/div R-type instruction in DX, captures the bypassed operands, and iterates one bit per cycle.
- Holds the pipeline (`mul_stall` high) until the result is ready, then presents the result and exception flag to the X/M latch for exactly one cycle.

Parameters:
- WIDTH, 32: operand/result width; iteration count equals WIDTH.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- dx_ir, input, 32: instruction currently in the D/X latch.
- dx_a, input, WIDTH: rs operand after bypass.
- dx_b, input, WIDTH: rt operand after bypass.
- mul_stall, output, 1: freeze PC, F/D and D/X; insert a nop into X/M.
- md_result, output, WIDTH: product low word or quotient; valid only when md_valid is high.
- md_valid, output, 1: one-cycle strobe; X/M selects md_result over the ALU output.
- md_exception, output, 1: qualified by md_valid; selects the exception write to $r30.

Behaviour:
- Decode rule: `dx_md = (dx_ir[31:27]==5'b00000) & (dx_ir[6:2]==5'b00110 (MUL) | dx_ir[6:2]==5'b00111 (DIV))`.
- States are IDLE, MUL, DIV, DONE. Reset (synchronous) forces IDLE, clears the counter and clears all registered datapath state.
- Output values while reset is high and after reset: mul_stall=0, md_valid=0, md_exception=0, md_result=0.
- IDLE:
  - `mul_stall = dx_md` (combinational) in the same cycle the instruction sits in DX.
  - If dx_md: latch dx_a, dx_b and the op, clear the counter, then go to MUL or DIV.
- MUL: radix-2 Booth, one step per cycle, 2*WIDTH+1-bit product register.
  - mul_stall=1.
  - After WIDTH steps (counter==WIDTH-1), go to DONE.
- DIV: non-restoring, on operand magnitudes, one quotient bit per cycle.
  - mul_stall=1.
  - After WIDTH steps, go to DONE.
  - The sign fix-up is applied combinationally in DONE.
- DONE (exactly one cycle), then IDLE:
  - mul_stall=0, md_valid=1.
  - The D/X instruction advances this cycle.
  - The next cycle returns to IDLE, so the same instruction is never restarted.
- Latency: DX entry at cycle N gives capture at N, iteration over N+1..N+WIDTH, DONE at N+WIDTH+1. mul_stall is high for WIDTH+1 cycles.
- MUL result rules:
  - md_result = product[WIDTH-1:0].
  - md_exception=1 if product[2*WIDTH-1:WIDTH-1] is not all-equal (signed overflow).
- DIV result rules:
  - Signed division, truncating toward zero; the remainder is discarded.
  - Divisor==0 gives md_result=0, md_exception=1, and still takes the full iteration count.
  - Dividend = -2^(WIDTH-1) with divisor = -1 gives md_result = -2^(WIDTH-1), md_exception=1.
- A non-md instruction in DX while in MUL/DIV is impossible, because D/X is frozen; operands are not re-sampled.
- Back-to-back md instructions: DONE→IDLE, then the next instruction is captured in IDLE. There is one non-stall cycle between them.
- Reset asserted mid-operation: abort, go to IDLE, no md_valid strobe, and the partial result is discarded.

Optional Feature:
- Macro: MULTDIV_EARLY_OUT_EN.
- When defined, the IDLE capture cycle goes directly to DONE in two cases:
  - MUL with either operand == 0: result 0, no exception.
  - DIV with divisor == 0: result 0, exception 1.
- Early-out total stall is 1 cycle.
- When undefined, all operations take the full WIDTH+1 stall cycles.

Decomposition:
- Package multdiv_pkg holds:
  - OP_RTYPE=5'b00000, ALU_MUL=5'b00110, ALU_DIV=5'b00111;
  - state encoding IDLE/MUL/DIV/DONE (2-bit);
  - WIDTH default.
- One sub-module, md_datapath, holds the Booth product register, the divide remainder/quotient registers, and the sign fix-up.
- multdiv_ctrl itself holds the FSM, counter, decode and stall logic.

Test Plan:
1. MUL 7 × -3 enters DX → mul_stall high 33 cycles, then md_valid=1, md_result=0xFFFFFFEB, md_exception=0, mul_stall=0 the same cycle.
2. MUL 0x00010000 × 0x00010000 → md_result=0x00000000, md_exception=1 at cycle 33.
3. DIV -7 / 2 → md_result=0xFFFFFFFD (-3), md_exception=0. DIV 0x80000000 / -1 → md_result=0x80000000, md_exception=1.
4. DIV 5 / 0:
   - without the macro: 33 stall cycles, then result 0, exception 1;
   - with MULTDIV_EARLY_OUT_EN: stall 1 cycle, DONE at cycle 1, result 0, exception 1.
5. Reset asserted at iteration 10 of a MUL → next cycle state IDLE, mul_stall=0 (unless dx_md), no md_valid pulse. The same instruction still in DX restarts cleanly and yields the correct product.
6. Back-to-back MUL 3×4 then DIV 12/4 → md_valid pulses twice with results 12 and 3. There is exactly one non-stall cycle between the stall windows; no double execution of either instruction.
